// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add MULT/MULTU, restoring DIV/DIVU, 1-cycle MTHI/MTLO.
// Optional build macro MULDIV_EARLY_OUT_EN: finish a multiply as soon as the remaining multiplier is zero.
module mips_muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clock_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int K  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(K) + 1;
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                is_mul, neg_hi, neg_lo;
    logic [2*WIDTH-1:0]  acc, mcand;
    logic [WIDTH-1:0]    mplier;

    logic [2*WIDTH-1:0]  mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]    mplier_next, hi_fix, lo_fix;
    logic                last_iter, mul_last, a_neg, b_neg, accept;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return sgn ? neg_w(v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] a,
                                                    input logic [2*WIDTH-1:0] mc,
                                                    input logic [WIDTH-1:0]   mp);
        logic [2*WIDTH-1:0] s;
        s = a;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            if (mp[i]) s = s + (mc << i);
        return s;
    endfunction

    // {rem, quo} packed in one word; quo shifts the dividend out as quotient bits shift in
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] rq,
                                                    input logic [WIDTH-1:0]   dvs);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] rem, quo;
        rem = rq[2*WIDTH-1:WIDTH];
        quo = rq[WIDTH-1:0];
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r   = {rem, quo[WIDTH-1]};
            quo = {quo[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, dvs}) begin
                r      = r - {1'b0, dvs};
                quo[0] = 1'b1;
            end
            rem = r[WIDTH-1:0];
        end
        return {rem, quo};
    endfunction

    always_comb begin
        a_neg       = ~op[0] & op_a[WIDTH-1];
        b_neg       = ~op[0] & op_b[WIDTH-1];
        accept      = start & ~abort & (state == S_IDLE);
        mul_next    = mul_step(acc, mcand, mplier);
        div_next    = div_step(acc, mcand[WIDTH-1:0]);
        mplier_next = mplier >> BITS_PER_CYCLE;
        last_iter   = (cnt == CW'(K - 1));
`ifdef MULDIV_EARLY_OUT_EN
        mul_last    = last_iter || (mplier_next == '0);
`else
        mul_last    = last_iter;
`endif
        prod_fix    = neg_lo ? neg_2w(acc) : acc;
        hi_fix      = neg_hi ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        lo_fix      = neg_lo ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        if (is_mul) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    assign busy = (state != S_IDLE);

    // control and architectural state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            is_mul <= 1'b0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
        end else if (clock_enable) begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    cnt <= '0;
                    if (op[2]) begin
                        if (!op[1] && !op[0]) hi <= op_a;
                        if (!op[1] &&  op[0]) lo <= op_a;
                    end else if (!op[1]) begin
                        state  <= S_MUL;
                        is_mul <= 1'b1;
                        neg_hi <= 1'b0;
                        neg_lo <= a_neg ^ b_neg;
                    end else begin
                        is_mul <= 1'b0;
                        if (op_b == '0) begin
                            state  <= S_FIX;
                            neg_hi <= 1'b0;
                            neg_lo <= 1'b0;
                        end else begin
                            state  <= S_DIV;
                            neg_hi <= a_neg;
                            neg_lo <= a_neg ^ b_neg;
                        end
                    end
                end
                S_MUL: if (abort) state <= S_IDLE;
                       else begin
                           cnt <= cnt + CW'(1);
                           if (mul_last) state <= S_FIX;
                       end
                S_DIV: if (abort) state <= S_IDLE;
                       else begin
                           cnt <= cnt + CW'(1);
                           if (last_iter) state <= S_FIX;
                       end
                default: begin
                    state <= S_IDLE;
                    if (!abort) begin
                        hi   <= hi_fix;
                        lo   <= lo_fix;
                        done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // datapath registers carry no reset; they are always loaded on accept
    always_ff @(posedge clk) begin
        if (clock_enable) begin
            if (accept && !op[2]) begin
                if (!op[1]) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, magnitude(op_a, a_neg)};
                    mplier <= magnitude(op_b, b_neg);
                end else begin
                    acc    <= (op_b == '0) ? {op_a, {WIDTH{1'b1}}}
                                           : {{WIDTH{1'b0}}, magnitude(op_a, a_neg)};
                    mcand  <= {{WIDTH{1'b0}}, magnitude(op_b, b_neg)};
                end
            end else if (state == S_MUL) begin
                acc    <= mul_next;
                mcand  <= mcand << BITS_PER_CYCLE;
                mplier <= mplier_next;
            end else if (state == S_DIV) begin
                acc    <= div_next;
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: expected HI/LO queued at issue, checked by a monitor on each done pulse.
module tb_mips_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic        clk, reset_n, clock_enable, start, abort;
    logic [2:0]  op;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          d0;
    logic [63:0] sb[$];
    logic [63:0] exp_mon;

    mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset_n(reset_n), .clock_enable(clock_enable), .start(start),
        .op(op), .op_a(op_a), .op_b(op_b), .abort(abort),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                exp_mon = sb.pop_front();
                check("done_result", {hi, lo}, exp_mon);
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int elat,
                          input bit expect_done, input int abort_at, input int stall_at,
                          input int ign_at, input string name);
        int n;
        if (expect_done) sb.push_back({eh, el});
        @(negedge clk);
        op = o; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            abort = (n == abort_at);
            start = (n == ign_at);
            if (n == ign_at) begin
                op   = 3'b100;
                op_a = 32'h0;
            end
            if (n == stall_at) clock_enable = 1'b0;
            else if (n == stall_at + 5) clock_enable = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        clock_enable = 1'b1;
        check({name, "_latency"}, 64'(n), 64'(elat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clock_enable = 1'b1; start = 1'b0; abort = 1'b0;
        op = 3'b0; op_a = '0; op_b = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // MTHI / MTLO
        @(negedge clk); op = 3'b100; op_a = 32'ha5a5a5a5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("mthi_hi", 64'(hi), 64'ha5a5a5a5);
        check("mthi_busy", 64'(busy), 64'd0);
        @(negedge clk); op = 3'b101; op_a = 32'h5a5a5a5a; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("mtlo_hilo", {hi, lo}, 64'ha5a5a5a5_5a5a5a5a);

        // abort on 10th busy cycle, ignored MTHI on 3rd
        d0 = done_cnt;
        run_op(3'b001, 32'h12345678, 32'h9abcdef0, 32'h0, 32'h0, 10, 1'b0, 10, 0, 3, "abort");
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'ha5a5a5a5_5a5a5a5a);
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // abort while idle drops a concurrent MTLO
        @(negedge clk); op = 3'b101; op_a = 32'hffff0000; start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("idle_abort_lo", 64'(lo), 64'h5a5a5a5a);
        check("idle_abort_busy", 64'(busy), 64'd0);

        d0 = done_cnt;
        run_op(3'b001, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 33, 1'b1, 0, 0, 0, "multu_max");
        @(negedge clk);
        check("multu_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("multu_done_low", 64'(done), 64'd0);

        run_op(3'b000, 32'hfffffffd, 32'h00000007, 32'hffffffff, 32'hffffffeb, EO ? 4 : 33, 1'b1, 0, 0, 0, "mult_neg");
        run_op(3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33, 1'b1, 0, 0, 0, "divu_7_2");
        run_op(3'b010, 32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd, 33, 1'b1, 0, 0, 0, "div_neg");
        run_op(3'b010, 32'h00001234, 32'h00000000, 32'h00001234, 32'hffffffff, 1, 1'b1, 0, 0, 0, "div_zero");
        run_op(3'b010, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 33, 1'b1, 0, 0, 0, "div_ovf");
        run_op(3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b1, 0, 0, 0, "mult_min");

        // asynchronous reset in the middle of a divide
        @(negedge clk); op = 3'b011; op_a = 32'd100; op_b = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_div_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_done", 64'(done), 64'd0);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 38, 1'b1, 0, 10, 0, "divu_stall");
        run_op(3'b001, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000f, EO ? 4 : 33, 1'b1, 0, 0, 0, "multu_3_5");

        @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
